// File: rtl/cpu_pkg.sv
// Shared definitions for the cycle sequencer: state encoding, opcode map and
// default datapath widths.
package cpu_pkg;

    localparam int PC_W_DEF = 8;
    localparam int OP_W_DEF = 4;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_DECODE,
        S_MEM,
        S_EXEC,
        S_HALT
    } state_t;

    localparam logic [3:0] OP_STORE = 4'h0;
    localparam logic [3:0] OP_ADD   = 4'h1;
    localparam logic [3:0] OP_SUB   = 4'h2;
    localparam logic [3:0] OP_MUL   = 4'h3;
    localparam logic [3:0] OP_DIV   = 4'h4;
    localparam logic [3:0] OP_AND   = 4'h5;
    localparam logic [3:0] OP_OR    = 4'h6;
    localparam logic [3:0] OP_NOT   = 4'h7;
    localparam logic [3:0] OP_XOR   = 4'h8;
    localparam logic [3:0] OP_XNOR  = 4'h9;
    localparam logic [3:0] OP_HALT  = 4'hE;
    localparam logic [3:0] OP_JMP   = 4'hF;

endpackage

// File: rtl/opcode_decoder.sv
// Combinational opcode classifier; opcodes matching no class (0xA..0xD) are NOPs.
module opcode_decoder
    import cpu_pkg::*;
#(
    parameter int OP_W = OP_W_DEF
) (
    input  logic [OP_W-1:0] op,
    output logic            is_store,
    output logic            is_alu,
    output logic            is_jmp,
    output logic            is_halt
);

    assign is_store = (op == OP_W'(OP_STORE));
    assign is_alu   = (op >= OP_W'(OP_ADD)) && (op <= OP_W'(OP_XNOR));
    assign is_jmp   = (op == OP_W'(OP_JMP));
    assign is_halt  = (op == OP_W'(OP_HALT));

endmodule

// File: rtl/cycle_sequencer.sv
// Multi-cycle fetch/decode/memory/execute controller for an accumulator CPU.
// All outputs are registered Moore outputs derived from the next state.
module cycle_sequencer
    import cpu_pkg::*;
#(
    parameter int PC_W = PC_W_DEF,
    parameter int OP_W = OP_W_DEF
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [OP_W+PC_W-1:0] instr_in,
    input  logic                 imem_ready,
    input  logic                 dmem_ready,
    output logic                 imem_req,
    output logic [PC_W-1:0]      pc_out,
    output logic                 dmem_read,
    output logic                 dmem_write,
    output logic [PC_W-1:0]      dmem_addr,
    output logic [OP_W-1:0]      alu_op,
    output logic                 ld_ac,
    output logic                 busy,
    output logic                 halted
);

    state_t                 state_reg, state_next;
    logic [PC_W-1:0]        pc_reg, pc_next;
    logic [OP_W+PC_W-1:0]   ir_reg, ir_next;
    logic                   is_store, is_alu, is_jmp, is_halt;

    opcode_decoder #(.OP_W(OP_W)) u_dec (
        .op       (ir_reg[OP_W+PC_W-1:PC_W]),
        .is_store (is_store),
        .is_alu   (is_alu),
        .is_jmp   (is_jmp),
        .is_halt  (is_halt)
    );

    always_comb begin
        state_next = state_reg;
        pc_next    = pc_reg;
        ir_next    = ir_reg;
        case (state_reg)
            S_IDLE: begin
                if (start) state_next = S_FETCH;
            end
            S_FETCH: begin
                if (imem_ready) begin
                    ir_next    = instr_in;
                    state_next = S_DECODE;
                end
            end
            S_DECODE: begin
                if (is_store || is_alu) begin
                    state_next = S_MEM;
                end else if (is_jmp) begin
                    pc_next    = ir_reg[PC_W-1:0];
                    state_next = S_FETCH;
                end else if (is_halt) begin
                    state_next = S_HALT;
                end else begin
                    pc_next    = pc_reg + 1'b1;
                    state_next = S_FETCH;
                end
            end
            S_MEM: begin
                if (dmem_ready) begin
                    if (is_store) begin
                        pc_next    = pc_reg + 1'b1;
                        state_next = S_FETCH;
                    end else begin
                        state_next = S_EXEC;
                    end
                end
            end
            S_EXEC: begin
                pc_next    = pc_reg + 1'b1;
                state_next = S_FETCH;
            end
            S_HALT: state_next = S_HALT;
            default: state_next = S_IDLE;
        endcase
    end

    // IR only changes on entry to DECODE, so the decoder flags already describe
    // the instruction whenever MEM is the next state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg  <= S_IDLE;
            pc_reg     <= '0;
            ir_reg     <= '0;
            imem_req   <= 1'b0;
            dmem_read  <= 1'b0;
            dmem_write <= 1'b0;
            dmem_addr  <= '0;
            alu_op     <= '0;
            ld_ac      <= 1'b0;
            busy       <= 1'b0;
            halted     <= 1'b0;
        end else begin
            state_reg  <= state_next;
            pc_reg     <= pc_next;
            ir_reg     <= ir_next;
            imem_req   <= (state_next == S_FETCH);
            dmem_read  <= (state_next == S_MEM) && is_alu;
            dmem_write <= (state_next == S_MEM) && is_store;
            dmem_addr  <= ir_next[PC_W-1:0];
            alu_op     <= ir_next[OP_W+PC_W-1:PC_W];
            ld_ac      <= (state_next == S_EXEC);
            busy       <= (state_next != S_IDLE) && (state_next != S_HALT);
            halted     <= (state_next == S_HALT);
        end
    end

    assign pc_out = pc_reg;

endmodule

// File: tb/tb_cycle_sequencer.sv
// Self-checking bench for cycle_sequencer: directed scenarios plus a randomized
// instruction stream compared against an instruction-level timing/PC model.
module tb_cycle_sequencer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [11:0] instr_in = '0;
    logic        imem_ready = 1'b0;
    logic        dmem_ready = 1'b0;
    logic        imem_req;
    logic [7:0]  pc_out;
    logic        dmem_read, dmem_write;
    logic [7:0]  dmem_addr;
    logic [3:0]  alu_op;
    logic        ld_ac, busy, halted;

    int          checks = 0;
    int          failures = 0;
    logic [7:0]  exp_pc = '0;

    cycle_sequencer #(.PC_W(8), .OP_W(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .instr_in   (instr_in),
        .imem_ready (imem_ready),
        .dmem_ready (dmem_ready),
        .imem_req   (imem_req),
        .pc_out     (pc_out),
        .dmem_read  (dmem_read),
        .dmem_write (dmem_write),
        .dmem_addr  (dmem_addr),
        .alu_op     (alu_op),
        .ld_ac      (ld_ac),
        .busy       (busy),
        .halted     (halted)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] out_vec();
        return {20'd0, imem_req, dmem_read, dmem_write, ld_ac, busy, halted, 6'd0}
             | {16'd0, pc_out, 8'd0} | {24'd0, dmem_addr} | {28'd0, alu_op};
    endfunction

    task automatic do_reset();
        @(posedge clk); #1;
        rst = 1'b1; start = 1'b0; imem_ready = 1'b0; dmem_ready = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        exp_pc = '0;
    endtask

    task automatic do_start();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    // One instruction from FETCH entry to the next FETCH entry. The model knows
    // only the instruction class, the injected wait states and the PC rule.
    task automatic run_instr(input logic [11:0] instr, input int di, input int dd);
        logic [3:0] op = instr[11:8];
        bit is_st  = (op == 4'h0);
        bit is_alu = (op >= 4'h1) && (op <= 4'h9);
        bit is_j   = (op == 4'hF);
        int exp_cyc = di + 2 + ((is_st || is_alu) ? dd + 1 : 0) + (is_alu ? 1 : 0);
        int cyc = 0, fcnt = 0, mcnt = 0, rd = 0, wr = 0, ld = 0;
        bit fetched = 0, done = 0, bad_addr = 0, bad_op = 0, bad_stat = 0;

        checks++;
        if (imem_req !== 1'b1) begin
            failures++;
            $display("FAIL entry_fetch: imem_req=%b required=1", imem_req);
        end
        while (!done && cyc < 64) begin
            if (fetched && imem_req === 1'b1) begin
                done = 1;
            end else begin
                cyc++;
                if (dmem_read === 1'b1) rd++;
                if (dmem_write === 1'b1) wr++;
                if (ld_ac === 1'b1) ld++;
                if ((dmem_read === 1'b1 || dmem_write === 1'b1) && dmem_addr !== instr[7:0]) bad_addr = 1;
                if ((dmem_read === 1'b1 || dmem_write === 1'b1 || ld_ac === 1'b1) && alu_op !== op) bad_op = 1;
                if (busy !== 1'b1 || halted !== 1'b0 || (dmem_read === 1'b1 && dmem_write === 1'b1)) bad_stat = 1;
                if (imem_req === 1'b1 && !fetched) begin
                    imem_ready = (fcnt == di);
                    if (fcnt == di) fetched = 1;
                    fcnt++;
                end else begin
                    imem_ready = 1'($urandom % 2);
                end
                instr_in = (imem_req === 1'b1 && imem_ready) ? instr : 12'($urandom);
                if (dmem_read === 1'b1 || dmem_write === 1'b1) begin
                    dmem_ready = (mcnt == dd);
                    mcnt++;
                end else begin
                    dmem_ready = 1'($urandom % 2);
                end
                start = 1'($urandom % 2);
                @(posedge clk); #1;
            end
        end
        imem_ready = 1'b0; dmem_ready = 1'b0; start = 1'b0;
        exp_pc = is_j ? instr[7:0] : exp_pc + 8'd1;

        checks += 9;
        if (!done) begin failures++; $display("FAIL done: timed out after %0d cycles, required return to FETCH", cyc); end
        if (cyc != exp_cyc) begin failures++; $display("FAIL cycles: instr=%h got=%0d required=%0d", instr, cyc, exp_cyc); end
        if (rd != (is_alu ? dd + 1 : 0)) begin failures++; $display("FAIL dmem_read_cycles: instr=%h got=%0d required=%0d", instr, rd, is_alu ? dd + 1 : 0); end
        if (wr != (is_st ? dd + 1 : 0)) begin failures++; $display("FAIL dmem_write_cycles: instr=%h got=%0d required=%0d", instr, wr, is_st ? dd + 1 : 0); end
        if (ld != (is_alu ? 1 : 0)) begin failures++; $display("FAIL ld_ac_cycles: instr=%h got=%0d required=%0d", instr, ld, is_alu ? 1 : 0); end
        if (bad_addr) begin failures++; $display("FAIL dmem_addr: instr=%h got=%h required=%h", instr, dmem_addr, instr[7:0]); end
        if (bad_op) begin failures++; $display("FAIL alu_op: instr=%h got=%h required=%h", instr, alu_op, op); end
        if (bad_stat) begin failures++; $display("FAIL busy_halted: instr=%h busy/halted/strobes wrong during execution, required busy=1 halted=0", instr); end
        if (pc_out !== exp_pc) begin failures++; $display("FAIL pc: instr=%h got=%h required=%h", instr, pc_out, exp_pc); end
        $display("txn instr=%h di=%0d dd=%0d cycles=%0d pc=%h", instr, di, dd, cyc, pc_out);
    endtask

    task automatic test_reset();
        #2;
        checks++;
        if (out_vec() !== 32'd0) begin failures++; $display("FAIL reset_outputs: got=%h required=0", out_vec()); end
        do_reset();
        for (int i = 0; i < 3; i++) begin
            imem_ready = 1'($urandom % 2); dmem_ready = 1'($urandom % 2);
            @(posedge clk); #1;
        end
        imem_ready = 1'b0; dmem_ready = 1'b0;
        checks++;
        if (out_vec() !== 32'd0) begin failures++; $display("FAIL idle_no_start: got=%h required=0", out_vec()); end
        $display("txn reset idle outputs=%h", out_vec());
    endtask

    task automatic test_add_fast();
        do_reset(); do_start();
        run_instr(12'h105, 0, 0);
    endtask

    task automatic test_store_delay();
        do_reset(); do_start();
        run_instr(12'h020, 0, 3);
    endtask

    task automatic test_jump_wrap();
        do_reset(); do_start();
        run_instr(12'hFFF, 0, 0);
        run_instr(12'hA00, 0, 0);
    endtask

    task automatic test_random();
        logic [3:0] op;
        do_reset(); do_start();
        for (int n = 0; n < 60; n++) begin
            do op = 4'($urandom); while (op == 4'hE);
            run_instr({op, 8'($urandom)}, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
        end
    endtask

    task automatic test_halt();
        bit bad = 0;
        do_reset(); do_start();
        run_instr(12'h0FE, 1, 1);
        instr_in = 12'hE00; imem_ready = 1'b1;
        @(posedge clk); #1;
        imem_ready = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (halted !== 1'b1 || busy !== 1'b0 || imem_req !== 1'b0 || pc_out !== exp_pc) begin
            failures++;
            $display("FAIL halt_entry: halted=%b busy=%b imem_req=%b pc=%h required 1 0 0 %h", halted, busy, imem_req, pc_out, exp_pc);
        end
        for (int i = 0; i < 6; i++) begin
            start = 1'($urandom % 2); imem_ready = 1'($urandom % 2); dmem_ready = 1'($urandom % 2);
            @(posedge clk); #1;
            if (halted !== 1'b1 || busy !== 1'b0 || imem_req !== 1'b0 || dmem_read !== 1'b0 ||
                dmem_write !== 1'b0 || ld_ac !== 1'b0 || pc_out !== exp_pc) bad = 1;
        end
        start = 1'b0; imem_ready = 1'b0; dmem_ready = 1'b0;
        checks++;
        if (bad) begin failures++; $display("FAIL halt_hold: halted=%b pc=%h required halted=1 pc=%h", halted, pc_out, exp_pc); end
        $display("txn halt pc=%h halted=%b", pc_out, halted);
    endtask

    task automatic test_reset_mid_mem();
        do_reset(); do_start();
        instr_in = 12'h105; imem_ready = 1'b1;
        @(posedge clk); #1;
        imem_ready = 1'b0; dmem_ready = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (dmem_read !== 1'b1) begin failures++; $display("FAIL mid_mem_read: got=%b required=1", dmem_read); end
        #2 rst = 1'b1;
        #1;
        checks++;
        if (out_vec() !== 32'd0) begin failures++; $display("FAIL async_reset: got=%h required=0", out_vec()); end
        @(posedge clk); #1;
        rst = 1'b0; exp_pc = '0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        checks++;
        if (imem_req !== 1'b0 || busy !== 1'b0) begin failures++; $display("FAIL post_reset_idle: imem_req=%b busy=%b required 0 0", imem_req, busy); end
        do_start();
        checks++;
        if (pc_out !== 8'h00) begin failures++; $display("FAIL restart_pc: got=%h required=00", pc_out); end
        run_instr(12'h105, 1, 2);
    endtask

    initial begin
        test_reset();
        test_add_fast();
        test_store_delay();
        test_jump_wrap();
        test_random();
        test_halt();
        test_reset_mid_mem();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/cycle_sequencer.md
CYCLE_SEQUENCER -- requirements
Module: cycle_sequencer

Interface
REQ-001 Parameter: PC_W, default 8, program/data address width.
REQ-002 Parameter: OP_W, default 4, opcode width.
REQ-003 Port: clk  input  1  sole clock; all state updates on rising edge.
REQ-004 Port: rst  input  1  asynchronous, active-high reset.
REQ-005 Port: start  input  1  leaves IDLE; sampled only in IDLE.
REQ-006 Port: instr_in  input  OP_W+PC_W  instruction word; opcode = [11:8], operand address = [7:0].
REQ-007 Port: imem_ready  input  1  instruction memory has valid instr_in this cycle.
REQ-008 Port: dmem_ready  input  1  data memory read/write completes this cycle.
REQ-009 Port: imem_req  output  1  instruction fetch request.
REQ-010 Port: pc_out  output  PC_W  current program counter.
REQ-011 Port: dmem_read, dmem_write  output  1 each  data memory strobes.
REQ-012 Port: dmem_addr  output  PC_W  operand address from IR[7:0].
REQ-013 Port: alu_op  output  OP_W  opcode from IR, held from DECODE through EXEC.
REQ-014 Port: ld_ac  output  1  accumulator load enable, single-cycle pulse.
REQ-015 Port: busy  output  1  high in every state except IDLE and HALT.
REQ-016 Port: halted  output  1  high in HALT.

Function
REQ-017 FSM states: IDLE, FETCH, DECODE, MEM, EXEC, HALT; Moore outputs only.
REQ-018 IDLE: all strobes low; start=1 -> FETCH next cycle; start outside IDLE ignored.
REQ-019 FETCH: imem_req=1 held until imem_ready=1; that edge: IR <= instr_in, -> DECODE; imem_ready outside FETCH ignored.
REQ-020 DECODE (1 cycle) on IR opcode:
- 0000 store -> MEM (write)
- 0001..1001 ALU ops (add, sub, mul, div, and, or, not, xor, xnor) -> MEM (read)
- 1111 jump -> pc <= IR[7:0], -> FETCH
- 1110 halt -> HALT
- 1010..1101 NOP -> pc <= pc+1, -> FETCH
REQ-021 MEM: dmem_addr=IR[7:0]; dmem_write=1 (store) or dmem_read=1 (ALU), held until dmem_ready=1; never both high.
REQ-022 MEM exit on dmem_ready: store -> pc <= pc+1, FETCH; ALU -> EXEC.
REQ-023 EXEC (1 cycle): ld_ac=1, pc <= pc+1, -> FETCH.
REQ-024 PC arithmetic modulo 2^PC_W; 255+1 wraps to 0; jump to 255 legal.
REQ-025 Minimum latency (ready high immediately): ALU 4 cycles, store 3, jump/NOP 2, FETCH-to-FETCH.
REQ-026 HALT: all strobes low, pc frozen; exit only via rst.
REQ-027 dmem_ready and imem_ready high together: only the one matching current state acts.

Reset
REQ-028 rst=1 (any state, mid-handshake included): state=IDLE, pc=0, IR=0, imem_req=dmem_read=dmem_write=ld_ac=busy=halted=0, alu_op=0, dmem_addr=0, effective immediately, no clock.
REQ-029 After rst deasserts: no activity until start=1.

Structure
REQ-030 Shared package cpu_pkg: state enum, opcode constants (OP_STORE, OP_ADD..OP_XNOR, OP_HALT, OP_JMP), PC_W/OP_W defaults.
REQ-031 One sub-module, opcode_decoder: combinational opcode -> {is_store, is_alu, is_jmp, is_halt}; all sequencing stays in cycle_sequencer.

Verification
REQ-032 rst, start; instr 0x1_05 (add), imem_ready and dmem_ready tied 1 -> dmem_read with dmem_addr=0x05 one cycle, ld_ac pulse next cycle, pc_out 0->1, 4 cycles total.
REQ-033 instr 0x0_20 (store), dmem_ready delayed 3 cycles -> dmem_write held 4 cycles at addr 0x20, dmem_read never high, ld_ac never high, pc_out=1.
REQ-034 pc=0, instr 0xF_FF (jump) then 0xA_00 (NOP) -> pc_out=0xFF after jump, 0x00 after NOP (wrap).
REQ-035 instr 0xE_00 -> halted=1, busy=0, pc frozen; further start and ready pulses -> no change until rst.
REQ-036 rst asserted mid-MEM with dmem_read=1 -> all outputs 0 without a clock edge; state IDLE; start restarts fetch at pc 0.
